// File: rtl/serial_addsub_n.sv
// serial_addsub_n: bit-serial two's-complement adder/subtractor.
// One bit per clock, LSB first; the result is published in one update when the
// last bit has been processed, so partial shift contents never reach the outputs.
module serial_addsub_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_mode;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_overflow;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic               w_b_bit;
  logic               w_bit;
  logic               w_cout;

  // Single full-adder slice; subtraction inverts B and seeds the carry with 1.
  always_comb begin
    w_b_bit = r_b[0] ^ r_mode;
    w_bit   = r_a[0] ^ w_b_bit ^ r_carry;
    w_cout  = (r_a[0] & w_b_bit) | (r_a[0] & r_carry) | (w_b_bit & r_carry);
    w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers, carry and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_mode  <= sub;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= {w_bit, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers, updated only on the final shift edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_step && w_last) begin
      r_sum       <= {w_bit, r_a[WIDTH-1:1]};
      r_carry_out <= w_cout;
      r_overflow  <= r_carry ^ w_cout;
    end
  end

  // Status flags registered from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == SHIFT);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Directed bench for serial_addsub_n with a result scoreboard (WIDTH=4 and WIDTH=8).
module tb_serial_addsub_n;

  logic       clk;
  logic       rst;

  logic       start4, sub4;
  logic [3:0] a4, b4, sum4;
  logic       cout4, ovf4, busy4, done4;

  logic       start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] q4[$];
  logic [9:0] q8[$];

  serial_addsub_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a_in(a4), .b_in(b4),
    .sum(sum4), .carry_out(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  serial_addsub_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
    .sum(sum8), .carry_out(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic [7:0] s, input logic c, input logic v);
    return {s, c, v};
  endfunction

  // Arithmetic reference: word-level add of A and (optionally inverted) B.
  function automatic logic [9:0] model(input int w, input bit sb, input int a, input int b);
    int mask, bb, full, s, c, v;
    mask = (1 << w) - 1;
    bb   = sb ? (~b & mask) : (b & mask);
    full = (a & mask) + bb + (sb ? 1 : 0);
    s    = full & mask;
    c    = (full >> w) & 1;
    v    = ((((a >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
            (((s >> (w-1)) & 1) != ((a >> (w-1)) & 1))) ? 1 : 0;
    return pk(8'(s), 1'(c), 1'(v));
  endfunction

  // Scoreboard consumers: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done4) begin
      check("overlap4", 16'(busy4 & done4), 16'd0);
      if (q4.size() == 0) check("unexpected_done4", 16'd1, 16'd0);
      else check("result4", 16'(pk({4'd0, sum4}, cout4, ovf4)), 16'(q4.pop_front()));
    end
    if (!rst && done8) begin
      check("overlap8", 16'(busy8 & done8), 16'd0);
      if (q8.size() == 0) check("unexpected_done8", 16'd1, 16'd0);
      else check("result8", 16'(pk(sum8, cout8, ovf8)), 16'(q8.pop_front()));
    end
  end

  // One operation from idle: checks latency, busy length, pulse width and hold.
  task automatic run_op(input bit w8, input bit sb, input logic [7:0] a, input logic [7:0] b,
                        input logic [9:0] exp);
    int w;
    int lat;
    int nbusy;
    w = w8 ? 8 : 4;
    lat = -1;
    nbusy = 0;
    if (w8) begin
      start8 = 1'b1; sub8 = sb; a8 = a; b8 = b; q8.push_back(exp);
    end else begin
      start4 = 1'b1; sub4 = sb; a4 = a[3:0]; b4 = b[3:0]; q4.push_back(exp);
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (w8 ? busy8 : busy4) nbusy++;
      @(posedge clk); #1;
      if (w8 ? done8 : done4) begin
        lat = k;
        break;
      end
    end
    check("latency", 16'(lat), 16'(w));
    check("busy_cycles", 16'(nbusy), 16'(w));
    @(posedge clk); #1;
    check("done_pulse", 16'(w8 ? done8 : done4), 16'd0);
    if (w8) check("hold8", 16'(pk(sum8, cout8, ovf8)), 16'(exp));
    else    check("hold4", 16'(pk({4'd0, sum4}, cout4, ovf4)), 16'(exp));
  endtask

  initial begin
    int seen_done;
    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset4", 16'({sum4, cout4, ovf4, busy4, done4}), 16'd0);
    check("reset8", 16'({sum8, cout8, ovf8, busy8, done8}), 16'd0);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 8'h0A, 8'h03, pk(8'h0D, 1'b0, 1'b0));
    run_op(1'b0, 1'b0, 8'h0F, 8'h01, pk(8'h00, 1'b1, 1'b0));
    run_op(1'b0, 1'b0, 8'h07, 8'h01, pk(8'h08, 1'b0, 1'b1));
    run_op(1'b0, 1'b1, 8'h03, 8'h05, pk(8'h0E, 1'b0, 1'b0));
    run_op(1'b1, 1'b1, 8'h80, 8'h01, pk(8'h7F, 1'b1, 1'b1));
    run_op(1'b1, 1'b0, 8'hFF, 8'h80, pk(8'h7F, 1'b1, 1'b1));

    // Start held high with operands scrambled every cycle.
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'd5; b4 = 4'd6;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      if (k % 6 == 0) q4.push_back(model(4, sub4, int'(a4), int'(b4)));
      #1;
      check("b2b_busy", 16'(busy4), 16'((k % 6) < 4));
      check("b2b_done", 16'(done4), 16'((k % 6) == 4));
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      sub4 = 1'($urandom_range(0, 1));
    end
    start4 = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Build a nonzero result, then abort the next operation with reset.
    run_op(1'b0, 1'b0, 8'h0A, 8'h03, pk(8'h0D, 1'b0, 1'b0));
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'h6; b4 = 4'h3;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 16'(busy4), 16'd0);
    check("abort_outs", 16'({sum4, cout4, ovf4, done4}), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done4) seen_done = 1;
    end
    check("abort_no_done", 16'(seen_done), 16'd0);
    check("abort_outs_hold", 16'({sum4, cout4, ovf4}), 16'd0);
    run_op(1'b0, 1'b0, 8'h01, 8'h01, pk(8'h02, 1'b0, 1'b0));

    check("q4_drained", 16'(q4.size()), 16'd0);
    check("q8_drained", 16'(q8.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub_n.md
SERIAL_ADDSUB_N -- requirements
Module: serial_addsub_n

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the operand and result width in bits; legal range is WIDTH >= 2.
REQ-002: clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-003: rst  input  1  SHALL be the asynchronous, active-high reset, acting immediately on assertion regardless of clk.
REQ-004: start  input  1  SHALL request an operation; it is sampled on the rising edge of clk.
REQ-005: sub  input  1  SHALL select the mode, sampled with start: 0 = A+B, 1 = A-B.
REQ-006: a_in  input  WIDTH  SHALL be operand A, sampled with start.
REQ-007: b_in  input  WIDTH  SHALL be operand B, sampled with start.
REQ-008: sum  output  WIDTH  SHALL be the registered result.
REQ-009: carry_out  output  1  SHALL be the final carry (subtract mode: 1 = no borrow).
REQ-010: overflow  output  1  SHALL be the two's-complement signed overflow flag.
REQ-011: busy  output  1  SHALL be high while serial computation is in progress.
REQ-012: done  output  1  SHALL be a one-cycle pulse marking that new results are valid.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014: In IDLE, start=1 at an edge SHALL do all of the following, then go to SHIFT:
- load A shift register <- a_in;
- load B shift register <- b_in;
- latch the sub mode;
- set the carry FF <- sub;
- clear the bit counter.
REQ-015: In SHIFT, each edge SHALL process one bit, LSB first:
- bit = A[0] ^ (B[0] ^ mode) ^ c;
- c <= majority(A[0], B[0]^mode, c);
- A shifts right with bit entering at the MSB;
- B shifts right;
- the counter increments.
REQ-016: On the WIDTH-th SHIFT edge, the FSM SHALL go to DONE and update the output registers in that same edge:
- sum <= final A contents;
- carry_out <= carry out of the MSB;
- overflow <= (carry into MSB) XOR (carry out of MSB).
REQ-017: Latency: done SHALL be high exactly WIDTH clock edges after the edge that accepted start, for exactly one cycle; DONE SHALL then go to IDLE unconditionally.
REQ-018: busy SHALL be 1 only in SHIFT, i.e. for exactly WIDTH cycles per operation; busy and done SHALL never be high together.
REQ-019: start SHALL be ignored in SHIFT and DONE, with no queuing; operand and mode changes during SHIFT SHALL NOT affect the result.
REQ-020: sum, carry_out and overflow SHALL hold their values from DONE through IDLE and the next SHIFT, until the next DONE update; intermediate shift contents SHALL never appear on them.
REQ-021: Back-to-back operation: start held high continuously SHALL yield one operation every WIDTH+2 cycles.
REQ-022: Arithmetic SHALL be modulo 2^WIDTH; no width extension is performed.

Reset
REQ-023: On rst=1, the block SHALL asynchronously:
- enter IDLE;
- clear the A, B, carry and counter registers;
- drive sum=0, carry_out=0, overflow=0, busy=0, done=0.
REQ-024: rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and outputs SHALL read 0.
REQ-025: After rst deasserts, the first edge with start=1 SHALL be accepted normally.
REQ-026: rst SHALL take priority over start when both are active.

Verification
REQ-027: WIDTH=4, add, a_in=1010, b_in=0011 -> done 4 edges after start; sum=1101, carry_out=0, overflow=0; busy high for 4 cycles.
REQ-028: WIDTH=4, add, 1111+0001 -> sum=0000, carry_out=1, overflow=0; add 0111+0001 -> sum=1000, carry_out=0, overflow=1.
REQ-029: WIDTH=4, sub, 0011-0101 -> sum=1110, carry_out=0, overflow=0.
REQ-030: WIDTH=8, sub, 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1; done 8 edges after start.
REQ-031: WIDTH=4, with start held high and a_in/b_in changed every cycle during SHIFT -> results match the operands sampled at acceptance; the next acceptance occurs 6 edges after the first.
REQ-032: WIDTH=4, rst pulsed during the 2nd SHIFT cycle -> busy=0 immediately, no done pulse, sum/carry_out/overflow=0; a following add of 0001+0001 -> sum=0010.
